// File: rtl/iob2axil.sv
// Native (IOb) slave to AXI4-Lite master bridge, one outstanding transaction.
// Nonzero wstrb issues an AW+W/B write; zero wstrb issues an AR/R read.
module iob2axil #(
    parameter int AXIL_ADDR_W = 32,
    parameter int AXIL_DATA_W = 32
) (
    input  logic                       clk,
    input  logic                       rst_n,

    input  logic                       valid,
    input  logic [AXIL_ADDR_W-1:0]     addr,
    input  logic [AXIL_DATA_W-1:0]     wdata,
    input  logic [AXIL_DATA_W/8-1:0]   wstrb,
    output logic [AXIL_DATA_W-1:0]     rdata,
    output logic                       ready,
    output logic                       error,

    output logic [AXIL_ADDR_W-1:0]     axil_awaddr,
    output logic [2:0]                 axil_awprot,
    output logic                       axil_awvalid,
    input  logic                       axil_awready,

    output logic [AXIL_DATA_W-1:0]     axil_wdata,
    output logic [AXIL_DATA_W/8-1:0]   axil_wstrb,
    output logic                       axil_wvalid,
    input  logic                       axil_wready,

    input  logic [1:0]                 axil_bresp,
    input  logic                       axil_bvalid,
    output logic                       axil_bready,

    output logic [AXIL_ADDR_W-1:0]     axil_araddr,
    output logic [2:0]                 axil_arprot,
    output logic                       axil_arvalid,
    input  logic                       axil_arready,

    input  logic [AXIL_DATA_W-1:0]     axil_rdata,
    input  logic [1:0]                 axil_rresp,
    input  logic                       axil_rvalid,
    output logic                       axil_rready
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] WREQ  = 3'd1;
    localparam logic [2:0] WRESP = 3'd2;
    localparam logic [2:0] RREQ  = 3'd3;
    localparam logic [2:0] RRESP = 3'd4;

    logic [2:0]               state;
    logic [AXIL_ADDR_W-1:0]   addr_q;
    logic [AXIL_DATA_W-1:0]   wdata_q;
    logic [AXIL_DATA_W/8-1:0] wstrb_q;

    // A single address register serves both the write and the read channel.
    assign axil_awaddr = addr_q;
    assign axil_araddr = addr_q;
    assign axil_wdata  = wdata_q;
    assign axil_wstrb  = wstrb_q;
    assign axil_awprot = '0;
    assign axil_arprot = '0;

    assign axil_bready = (state == WRESP);
    assign axil_rready = (state == RRESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            addr_q       <= '0;
            wdata_q      <= '0;
            wstrb_q      <= '0;
            axil_awvalid <= 1'b0;
            axil_wvalid  <= 1'b0;
            axil_arvalid <= 1'b0;
            ready        <= 1'b0;
            error        <= 1'b0;
            rdata        <= '0;
        end else begin
            ready <= 1'b0;
            error <= 1'b0;
            case (state)
                IDLE: begin
                    // valid is still high during the ready cycle; ignore it there.
                    if (valid && !ready) begin
                        addr_q  <= addr;
                        wdata_q <= wdata;
                        wstrb_q <= wstrb;
                        if (|wstrb) begin
                            axil_awvalid <= 1'b1;
                            axil_wvalid  <= 1'b1;
                            state        <= WREQ;
                        end else begin
                            axil_arvalid <= 1'b1;
                            state        <= RREQ;
                        end
                    end
                end
                WREQ: begin
                    if (axil_awvalid && axil_awready) axil_awvalid <= 1'b0;
                    if (axil_wvalid && axil_wready)   axil_wvalid  <= 1'b0;
                    // Each channel is done if already accepted or accepted on this edge.
                    if ((!axil_awvalid || axil_awready) && (!axil_wvalid || axil_wready))
                        state <= WRESP;
                end
                WRESP: begin
                    if (axil_bvalid) begin
                        ready <= 1'b1;
                        error <= |axil_bresp;
                        state <= IDLE;
                    end
                end
                RREQ: begin
                    if (axil_arready) begin
                        axil_arvalid <= 1'b0;
                        state        <= RRESP;
                    end
                end
                RRESP: begin
                    if (axil_rvalid) begin
                        rdata <= axil_rdata;
                        error <= |axil_rresp;
                        ready <= 1'b1;
                        state <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_iob2axil.sv
// Self-checking bench for iob2axil: configurable-latency AXI4-Lite slave,
// per-cycle channel checks and a scoreboard of expected native completions.
module tb_iob2axil;

    localparam int AW = 32;
    localparam int DW = 32;

    logic            clk;
    logic            rst_n;
    logic            valid;
    logic [AW-1:0]   addr;
    logic [DW-1:0]   wdata;
    logic [DW/8-1:0] wstrb;
    logic [DW-1:0]   rdata;
    logic            ready;
    logic            error;
    logic [AW-1:0]   axil_awaddr;
    logic [2:0]      axil_awprot;
    logic            axil_awvalid;
    logic            axil_awready;
    logic [DW-1:0]   axil_wdata;
    logic [DW/8-1:0] axil_wstrb;
    logic            axil_wvalid;
    logic            axil_wready;
    logic [1:0]      axil_bresp;
    logic            axil_bvalid;
    logic            axil_bready;
    logic [AW-1:0]   axil_araddr;
    logic [2:0]      axil_arprot;
    logic            axil_arvalid;
    logic            axil_arready;
    logic [DW-1:0]   axil_rdata;
    logic [1:0]      axil_rresp;
    logic            axil_rvalid;
    logic            axil_rready;

    iob2axil #(.AXIL_ADDR_W(AW), .AXIL_DATA_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .valid(valid), .addr(addr), .wdata(wdata), .wstrb(wstrb),
        .rdata(rdata), .ready(ready), .error(error),
        .axil_awaddr(axil_awaddr), .axil_awprot(axil_awprot),
        .axil_awvalid(axil_awvalid), .axil_awready(axil_awready),
        .axil_wdata(axil_wdata), .axil_wstrb(axil_wstrb),
        .axil_wvalid(axil_wvalid), .axil_wready(axil_wready),
        .axil_bresp(axil_bresp), .axil_bvalid(axil_bvalid), .axil_bready(axil_bready),
        .axil_araddr(axil_araddr), .axil_arprot(axil_arprot),
        .axil_arvalid(axil_arvalid), .axil_arready(axil_arready),
        .axil_rdata(axil_rdata), .axil_rresp(axil_rresp),
        .axil_rvalid(axil_rvalid), .axil_rready(axil_rready)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Slave behaviour knobs, set before each request.
    int          aw_dly = 0, w_dly = 0, b_dly = 0, ar_dly = 0, r_dly = 0;
    logic [1:0]  bresp_cfg = 2'b00;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] rdata_cfg = '0;

    int aw_hs = 0, w_hs = 0, b_hs = 0, ar_hs = 0, r_hs = 0;

    typedef struct {
        bit          is_read;
        logic [31:0] rdata;
        bit          err;
    } exp_t;

    exp_t        sb[$];
    logic [31:0] last_rdata = '0;

    // AXI4-Lite slave: all decisions at negedge; a handshake counted here
    // completes on the following posedge.
    initial begin : slave
        int  aw_cnt, w_cnt, b_cnt, ar_cnt, r_cnt;
        bit  aw_got, w_got, b_phase, b_fire, r_phase, r_fire;
        aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
        aw_got = 0; w_got = 0; b_phase = 0; b_fire = 0; r_phase = 0; r_fire = 0;
        axil_awready = 0; axil_wready = 0; axil_arready = 0;
        axil_bvalid = 0; axil_bresp = 0; axil_rvalid = 0; axil_rresp = 0; axil_rdata = 0;
        forever begin
            @(negedge clk);
            if (!rst_n) begin
                aw_cnt = 0; w_cnt = 0; b_cnt = 0; ar_cnt = 0; r_cnt = 0;
                aw_got = 0; w_got = 0; b_phase = 0; b_fire = 0; r_phase = 0; r_fire = 0;
                axil_awready = 0; axil_wready = 0; axil_arready = 0;
                axil_bvalid = 0; axil_rvalid = 0;
                continue;
            end
            // Response channels first so B/R never appear before the request completes.
            if (b_fire) begin axil_bvalid = 0; b_fire = 0; end
            if (b_phase) begin
                if (b_cnt >= b_dly) begin axil_bvalid = 1; axil_bresp = bresp_cfg; end
                else b_cnt++;
                if (axil_bvalid && axil_bready) begin b_fire = 1; b_phase = 0; b_hs++; end
            end
            if (r_fire) begin axil_rvalid = 0; r_fire = 0; end
            if (r_phase) begin
                if (r_cnt >= r_dly) begin
                    axil_rvalid = 1; axil_rdata = rdata_cfg; axil_rresp = rresp_cfg;
                end else r_cnt++;
                if (axil_rvalid && axil_rready) begin r_fire = 1; r_phase = 0; r_hs++; end
            end
            if (axil_awvalid) begin axil_awready = (aw_cnt >= aw_dly); aw_cnt++; end
            else begin axil_awready = 0; aw_cnt = 0; end
            if (axil_awvalid && axil_awready) begin aw_hs++; aw_got = 1; end
            if (axil_wvalid) begin axil_wready = (w_cnt >= w_dly); w_cnt++; end
            else begin axil_wready = 0; w_cnt = 0; end
            if (axil_wvalid && axil_wready) begin w_hs++; w_got = 1; end
            if (aw_got && w_got) begin aw_got = 0; w_got = 0; b_phase = 1; b_cnt = 0; end
            if (axil_arvalid) begin axil_arready = (ar_cnt >= ar_dly); ar_cnt++; end
            else begin axil_arready = 0; ar_cnt = 0; end
            if (axil_arvalid && axil_arready) begin ar_hs++; r_phase = 1; r_cnt = 0; end
        end
    end

    // Scoreboard: every native completion pops one expectation.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (rst_n && ready) begin
                if (sb.size() == 0) begin
                    check_eq("spurious_ready", 64'(ready), 64'(0));
                end else begin
                    e = sb.pop_front();
                    check_eq("error", 64'(error), 64'(e.err));
                    check_eq("rdata", 64'(rdata), 64'(e.is_read ? e.rdata : last_rdata));
                    if (e.is_read) last_rdata = e.rdata;
                end
            end
        end
    end

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    task automatic run_req(input logic [31:0] a, input logic [31:0] d,
                           input logic [3:0] s, input bit hold);
        exp_t e;
        bit   is_rd, done;
        int   c, lat, mx;
        int   aw0, w0, b0, ar0, r0;
        is_rd = (s == 4'h0);
        mx    = (aw_dly > w_dly) ? aw_dly : w_dly;
        lat   = is_rd ? 3 + ar_dly + r_dly : 3 + mx + b_dly;
        aw0 = aw_hs; w0 = w_hs; b0 = b_hs; ar0 = ar_hs; r0 = r_hs;
        e.is_read = is_rd;
        e.rdata   = rdata_cfg;
        e.err     = is_rd ? (rresp_cfg != 2'b00) : (bresp_cfg != 2'b00);
        sb.push_back(e);
        valid = 1'b1; addr = a; wdata = d; wstrb = s;
        c = 0; done = 0;
        while (!done && c < 200) begin
            tick();
            c++;
            if (!is_rd) begin
                check_eq("awvalid", 64'(axil_awvalid), 64'(c <= 1 + aw_dly));
                check_eq("wvalid", 64'(axil_wvalid), 64'(c <= 1 + w_dly));
                check_eq("bready", 64'(axil_bready), 64'(c >= 2 + mx && c < lat));
                if (axil_awvalid) begin
                    check_eq("awaddr", 64'(axil_awaddr), 64'(a));
                    check_eq("awprot", 64'(axil_awprot), 64'(0));
                end
                if (axil_wvalid) begin
                    check_eq("wdata", 64'(axil_wdata), 64'(d));
                    check_eq("wstrb", 64'(axil_wstrb), 64'(s));
                end
                check_eq("arvalid_on_write", 64'(axil_arvalid), 64'(0));
            end else begin
                check_eq("arvalid", 64'(axil_arvalid), 64'(c <= 1 + ar_dly));
                check_eq("rready", 64'(axil_rready), 64'(c >= 2 + ar_dly && c < lat));
                if (axil_arvalid) begin
                    check_eq("araddr", 64'(axil_araddr), 64'(a));
                    check_eq("arprot", 64'(axil_arprot), 64'(0));
                end
                check_eq("awvalid_on_read", 64'(axil_awvalid), 64'(0));
            end
            if (ready) done = 1;
        end
        check_eq("latency", 64'(c), 64'(lat));
        check_eq("aw_count", 64'(aw_hs - aw0), 64'(is_rd ? 0 : 1));
        check_eq("w_count",  64'(w_hs - w0),   64'(is_rd ? 0 : 1));
        check_eq("b_count",  64'(b_hs - b0),   64'(is_rd ? 0 : 1));
        check_eq("ar_count", 64'(ar_hs - ar0), 64'(is_rd ? 1 : 0));
        check_eq("r_count",  64'(r_hs - r0),   64'(is_rd ? 1 : 0));
        // valid stays high through the ready cycle; the pulse must be one cycle wide.
        tick();
        check_eq("ready_pulse", 64'(ready), 64'(0));
        check_eq("no_restart", 64'(axil_awvalid | axil_arvalid), 64'(0));
        if (!hold) begin
            valid = 1'b0; wstrb = '0;
            tick();
        end
    endtask

    task automatic set_dly(input int a, input int w, input int b, input int ar, input int r);
        aw_dly = a; w_dly = w; b_dly = b; ar_dly = ar; r_dly = r;
    endtask

    initial begin : main
        int c;
        rst_n = 1'b0; valid = 1'b0; addr = '0; wdata = '0; wstrb = '0;
        repeat (3) tick();
        check_eq("rst_ready", 64'(ready), 64'(0));
        check_eq("rst_error", 64'(error), 64'(0));
        check_eq("rst_rdata", 64'(rdata), 64'(0));
        check_eq("rst_valids", 64'({axil_awvalid, axil_wvalid, axil_arvalid}), 64'(0));
        check_eq("rst_readies", 64'({axil_bready, axil_rready}), 64'(0));
        rst_n = 1'b1;
        tick();

        set_dly(0, 0, 0, 0, 0);
        run_req(32'h10, 32'hDEADBEEF, 4'hF, 0);

        set_dly(3, 0, 0, 0, 0);
        run_req(32'h14, 32'hA5A51234, 4'h3, 0);

        set_dly(0, 0, 0, 2, 4);
        rdata_cfg = 32'h12345678;
        run_req(32'h24, 32'h0, 4'h0, 0);
        set_dly(0, 2, 1, 0, 0);
        run_req(32'h28, 32'h0BADF00D, 4'hC, 0);

        set_dly(0, 0, 0, 1, 0);
        rdata_cfg = 32'hCAFEF00D; rresp_cfg = 2'b10;
        run_req(32'h2C, 32'h0, 4'h0, 0);
        rresp_cfg = 2'b00;
        set_dly(1, 0, 2, 0, 0);
        bresp_cfg = 2'b11;
        run_req(32'h30, 32'h11223344, 4'h1, 0);
        bresp_cfg = 2'b00;

        set_dly(0, 1, 0, 0, 1);
        rdata_cfg = 32'h55AA0FF0;
        run_req(32'h40, 32'h01020304, 4'hF, 1);
        run_req(32'h44, 32'h0, 4'h0, 1);
        run_req(32'h48, 32'hFFFF0000, 4'h8, 0);

        // Reset while waiting for B: outputs clear at once, not at a clock edge.
        set_dly(0, 0, 20, 0, 0);
        valid = 1'b1; addr = 32'h50; wdata = 32'h77777777; wstrb = 4'hF;
        c = 0;
        while (!axil_bready && c < 20) begin tick(); c++; end
        check_eq("reach_wresp", 64'(axil_bready), 64'(1));
        valid = 1'b0; wstrb = '0;
        rst_n = 1'b0;
        #1;
        check_eq("arst_ready_error", 64'({ready, error}), 64'(0));
        check_eq("arst_rdata", 64'(rdata), 64'(0));
        check_eq("arst_valids", 64'({axil_awvalid, axil_wvalid, axil_arvalid}), 64'(0));
        check_eq("arst_readies", 64'({axil_bready, axil_rready}), 64'(0));
        check_eq("arst_awaddr", 64'(axil_awaddr), 64'(0));
        check_eq("arst_wdata", 64'(axil_wdata), 64'(0));
        check_eq("arst_wstrb", 64'(axil_wstrb), 64'(0));
        last_rdata = '0;
        repeat (2) tick();
        rst_n = 1'b1;
        tick();
        set_dly(0, 0, 0, 0, 0);
        rdata_cfg = 32'h600DCAFE;
        run_req(32'h60, 32'h0, 4'h0, 0);

        repeat (3) tick();
        check_eq("sb_empty", 64'(sb.size()), 64'(0));
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/iob2axil.md
# iob2axil

Bridge from the native (IOb) slave interface to an AXI4-Lite master interface. A CPU-side native request (valid/addr/wdata/wstrb) is converted into a single AXI4-Lite write (AW+W, then B) or read (AR, then R) transaction, and completion is returned as a one-cycle native `ready` pulse. It sits between a native-bus master and AXI4-Lite peripherals or interconnect, and it handles one outstanding transaction at a time.

## Interface
- `AXIL_ADDR_W`, 32, address width in bits
- `AXIL_DATA_W`, 32, data width in bits (multiple of 8)

- `clk`  in  1  clock; all logic on the rising edge
- `rst_n`  in  1  asynchronous, active-low reset
- `valid`  in  1  native request; held by the master until `ready`
- `addr`  in  AXIL_ADDR_W  native byte address
- `wdata`  in  AXIL_DATA_W  native write data
- `wstrb`  in  AXIL_DATA_W/8  byte enables; nonzero = write, zero = read
- `rdata`  out  AXIL_DATA_W  read data, valid while `ready`=1 on reads
- `ready`  out  1  one-cycle completion pulse
- `error`  out  1  high with `ready` if the AXI response was not OKAY
- `axil_awaddr`  out  AXIL_ADDR_W;  `axil_awprot`  out  3 (constant 0);  `axil_awvalid`  out  1;  `axil_awready`  in  1
- `axil_wdata`  out  AXIL_DATA_W;  `axil_wstrb`  out  AXIL_DATA_W/8;  `axil_wvalid`  out  1;  `axil_wready`  in  1
- `axil_bresp`  in  2;  `axil_bvalid`  in  1;  `axil_bready`  out  1
- `axil_araddr`  out  AXIL_ADDR_W;  `axil_arprot`  out  3 (constant 0);  `axil_arvalid`  out  1;  `axil_arready`  in  1
- `axil_rdata`  in  AXIL_DATA_W;  `axil_rresp`  in  2;  `axil_rvalid`  in  1;  `axil_rready`  out  1

## Operation
- FSM states: IDLE, WREQ, WRESP, RREQ, RRESP.
- IDLE: if `valid & ~ready`, latch `addr`, `wdata` and `wstrb` into the AXI address, data and strobe registers. If `wstrb`≠0, set `awvalid`=`wvalid`=1 and go to WREQ. Otherwise set `arvalid`=1 and go to RREQ.
- The `~ready` gate is mandatory. In the cycle where `ready`=1, the master's `valid` is still high and must not start a new transaction.
- WREQ: AW and W channels complete independently.
  - `awvalid` clears on the edge where `awvalid & awready`.
  - `wvalid` clears on the edge where `wvalid & wready`.
  - When both have been accepted (same edge or different edges), go to WRESP.
  - Neither valid ever drops before its handshake, and latched address, data and strobe are stable while their valid is high.
- WRESP: `bready`=1 (combinational from state). On `bvalid`, go to IDLE; next cycle `ready`=1 and `error`=(`bresp`≠0). `rdata` is unchanged on writes.
- RREQ: `arvalid` held until `arready`. On the handshake edge, clear `arvalid` and go to RRESP.
- RRESP: `rready`=1 (combinational from state). On `rvalid`, register `rdata`←`axil_rdata` and `error`←(`rresp`≠0), set `ready`=1, go to IDLE.
- `ready` and `error` are registered one-cycle pulses. `rdata` holds its value until the next read completes.
- Reset (asynchronous, any state): state=IDLE. `ready`, `error`, `rdata`, all AXI valids, addr/data/strobe registers = 0. `bready`=`rready`=0. An in-flight AXI transaction is abandoned; the system must reset the slave too.

## Timing
- Write, zero-wait slave: valid at cycle 0 → `awvalid`/`wvalid` at cycle 1 (accepted at 1) → `bready` at cycle 2, `bvalid` at 2 → `ready` at cycle 3. Minimum latency is 3 cycles.
- Read, zero-wait slave: `arvalid` at cycle 1 → `rready` at cycle 2 → `ready` plus `rdata` at cycle 3.
- Each slave wait cycle on AW/W, B, AR or R adds exactly one cycle.
- Back-to-back: the earliest next `awvalid`/`arvalid` is 2 cycles after `ready` (master drops or re-presents `valid` in the cycle after `ready`).
- No combinational path from AXI inputs to AXI outputs except `bready`/`rready`, which depend on state only.

## Test plan
- Write with zero-wait slave: addr=0x10, wdata=0xDEADBEEF, wstrb=0xF → AW/W both at cycle 1 with those values, `ready` at cycle 3, `error`=0, exactly one AW and one W handshake.
- Split write acceptance: `awready` delayed 3 cycles, `wready` immediate, wstrb=0x3 → `wvalid` drops after cycle 1, `awvalid` held to cycle 4, `bready` from cycle 5, `axil_wstrb`=0x3 throughout.
- Read with wait states: addr=0x24, `arready` 2 cycles late, `rvalid` 4 cycles after AR handshake with rdata=0x12345678 → `ready` one cycle after R handshake, `rdata`=0x12345678 and held afterwards.
- Error response: read returning rresp=2'b10 → `ready` and `error` high together for one cycle. Write returning bresp=2'b11 → same.
- Valid held through `ready` and a new request issued in the next cycle → exactly one AXI transaction per request, no duplicate AW/AR.
- `rst_n` asserted while in WRESP with `bvalid` low → all outputs 0 immediately. After release, a new read completes normally.
